// File: rtl/keyboard_key_event_gen.sv
// Per-key debounce with registered press/release pulses and an optional typematic repeat.
// Define KEY_EVENT_AUTO_REPEAT_EN to build the per-key repeat FSM; otherwise key_repeat is tied low.
module keyboard_key_event_gen #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_pressed_posedge,
  output logic [N_KEYS-1:0] key_released_negedge,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_any
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync_q;
  logic [N_KEYS-1:0] state_d;
  logic              any_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      any_q  <= 1'b0;
    end else begin
      sync_q <= key_pressed;
      any_q  <= |state_d;
    end
  end

  assign key_any = any_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_debounce
      logic            st_q, st_d;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            rise_q, fall_q;

      // Any agreeing sample drops the count back to zero, so glitches never accumulate.
      always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        if (sync_q[gi] != st_q) begin
          if (cnt_q == DB_LAST) begin
            st_d = sync_q[gi];
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q   <= 1'b0;
          cnt_q  <= '0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          st_q   <= st_d;
          cnt_q  <= cnt_d;
          rise_q <= st_d & ~st_q;
          fall_q <= ~st_d & st_q;
        end
      end

      assign state_d[gi]              = st_d;
      assign key_state[gi]            = st_q;
      assign key_pressed_posedge[gi]  = rise_q;
      assign key_released_negedge[gi] = fall_q;
    end
  endgenerate

`ifdef KEY_EVENT_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_repeat
      rep_state_e    rs_q, rs_d;
      logic [RW-1:0] rc_q, rc_d;
      logic          pulse_d, pulse_q;
      logic          rise, fall;

      assign rise = state_d[gi] & ~key_state[gi];
      assign fall = ~state_d[gi] & key_state[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          rs_q    <= ST_IDLE;
          rc_q    <= '0;
          pulse_q <= 1'b0;
        end else begin
          rs_q    <= rs_d;
          rc_q    <= rc_d;
          pulse_q <= pulse_d;
        end
      end

      // Release wins over everything, including a count expiring in the same cycle.
      always_comb begin
        rs_d = rs_q;
        rc_d = rc_q;
        if (fall) begin
          rs_d = ST_IDLE;
          rc_d = '0;
        end else begin
          case (rs_q)
            ST_IDLE: begin
              rc_d = '0;
              if (rise) rs_d = ST_DELAY;
            end
            ST_DELAY: begin
              if (rc_q == RD_LAST) begin
                rc_d = '0;
                rs_d = ST_REPEAT;
              end else begin
                rc_d = rc_q + RW'(1);
              end
            end
            ST_REPEAT: begin
              if (rc_q == RP_LAST) rc_d = '0;
              else                 rc_d = rc_q + RW'(1);
            end
            default: begin
              rs_d = ST_IDLE;
              rc_d = '0;
            end
          endcase
        end
      end

      always_comb begin
        pulse_d = 1'b0;
        if (!fall) begin
          if (rs_q == ST_DELAY && rc_q == RD_LAST)  pulse_d = 1'b1;
          if (rs_q == ST_REPEAT && rc_q == RP_LAST) pulse_d = 1'b1;
        end
      end

      assign key_repeat[gi] = pulse_q;
    end
  endgenerate
`else
  assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_keyboard_key_event_gen.sv
// Directed bench for keyboard_key_event_gen: debounce latency, glitch rejection,
// release, auto-repeat timing (when KEY_EVENT_AUTO_REPEAT_EN is defined), multi-key and reset.
`timescale 1ns/1ps
module tb_keyboard_key_event_gen;

`ifdef KEY_EVENT_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] key_pressed;
  logic [3:0] key_state;
  logic [3:0] key_pressed_posedge;
  logic [3:0] key_released_negedge;
  logic [3:0] key_repeat;
  logic       key_any;

  int n_tests;
  int n_fail;

  keyboard_key_event_gen #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_pressed(key_pressed),
    .key_state(key_state),
    .key_pressed_posedge(key_pressed_posedge),
    .key_released_negedge(key_released_negedge),
    .key_repeat(key_repeat),
    .key_any(key_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    key_pressed = 4'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    key_pressed = 4'hF;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({key_state, key_pressed_posedge, key_released_negedge, key_repeat, key_any} !== 17'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got st=%b pe=%b ne=%b rp=%b any=%b exp all 0",
                 i, key_state, key_pressed_posedge, key_released_negedge, key_repeat, key_any);
      end
    end
    rst = 1'b0;
    key_pressed = 4'h0;
    tick();
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_clean_press();
    logic exp;
    apply_reset();
    key_pressed[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i == 5);
      n_tests++;
      if (key_state[0] !== exp || key_pressed_posedge[0] !== exp || key_any !== exp) begin
        n_fail++;
        $display("FAIL clean_press edge+%0d got st=%b pe=%b any=%b exp %b", i,
                 key_state[0], key_pressed_posedge[0], key_any, exp);
      end
    end
    tick();
    n_tests++;
    if (key_pressed_posedge[0] !== 1'b0 || key_state[0] !== 1'b1 || key_any !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_pulse_width got pe=%b st=%b any=%b exp pe=0 st=1 any=1",
               key_pressed_posedge[0], key_state[0], key_any);
    end
    $display("[TB] test_clean_press done");
  endtask

  task automatic test_bounce();
    int   seq [4];
    int   pulses;
    logic exp;
    seq = '{1, 0, 1, 0};
    pulses = 0;
    apply_reset();
    for (int j = 0; j < 4; j++) begin
      key_pressed[1] = seq[j][0];
      tick();
      n_tests++;
      if (key_pressed_posedge[1] !== 1'b0 || key_state[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_toggle step %0d got pe=%b st=%b exp 0", j,
                 key_pressed_posedge[1], key_state[1]);
      end
    end
    key_pressed[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i == 5);
      if (key_pressed_posedge[1] === 1'b1) pulses++;
      n_tests++;
      if (key_pressed_posedge[1] !== exp || key_state[1] !== (i >= 5)) begin
        n_fail++;
        $display("FAIL bounce_settle edge+%0d got pe=%b st=%b exp pe=%b st=%b", i,
                 key_pressed_posedge[1], key_state[1], exp, (i >= 5));
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_pulse_count got %0d exp 1", pulses);
    end
    $display("[TB] test_bounce done");
  endtask

  task automatic test_release();
    int reps;
    reps = 0;
    apply_reset();
    key_pressed[2] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (key_pressed_posedge[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL release_press got pe=%b exp 1", key_pressed_posedge[2]);
    end
    // Release timed so the debounced fall lands where a repeat pulse would otherwise fire.
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (key_repeat[2] === 1'b1) reps++;
    end
    n_tests++;
    if (reps != (REP_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL release_held_repeats got %0d exp %0d", reps, (REP_EN ? 1 : 0));
    end
    key_pressed[2] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_tests++;
      if (key_released_negedge[2] !== (i == 5) || key_state[2] !== (i < 5) ||
          key_repeat[2] !== 1'b0 || key_pressed_posedge[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL release edge+%0d got ne=%b st=%b rp=%b pe=%b exp ne=%b st=%b rp=0 pe=0",
                 i, key_released_negedge[2], key_state[2], key_repeat[2],
                 key_pressed_posedge[2], (i == 5), (i < 5));
      end
    end
    reps = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (key_repeat[2] !== 1'b0 || key_released_negedge[2] !== 1'b0) reps++;
    end
    n_tests++;
    if (reps != 0) begin
      n_fail++;
      $display("FAIL release_quiet got %0d active cycles exp 0", reps);
    end
    $display("[TB] test_release done");
  endtask

  task automatic test_auto_repeat();
    logic exp;
    apply_reset();
    key_pressed[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (key_pressed_posedge[3] !== 1'b1 || key_repeat[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_press got pe=%b rp=%b exp pe=1 rp=0",
               key_pressed_posedge[3], key_repeat[3]);
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp = REP_EN && (k >= 20) && (k <= 52) && (((k - 20) % 8) == 0);
      n_tests++;
      if (key_repeat[3] !== exp || key_pressed_posedge[3] !== 1'b0 ||
          key_released_negedge[3] !== (k == 60)) begin
        n_fail++;
        $display("FAIL repeat press+%0d got rp=%b pe=%b ne=%b exp rp=%b pe=0 ne=%b",
                 k, key_repeat[3], key_pressed_posedge[3], key_released_negedge[3],
                 exp, (k == 60));
      end
      if (k == 55) key_pressed[3] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_tests++;
      if (key_repeat[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL repeat_after_release cycle %0d got rp=%b exp 0", i, key_repeat[3]);
      end
    end
    $display("[TB] test_auto_repeat done");
  endtask

  task automatic test_multi_key();
    apply_reset();
    key_pressed = 4'b0101;
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (key_state !== 4'b0101 || key_any !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_setup got st=%b any=%b exp st=0101 any=1", key_state, key_any);
    end
    key_pressed = 4'b0110;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 5) begin
        n_tests++;
        if (key_pressed_posedge !== 4'b0000 || key_released_negedge !== 4'b0000 ||
            key_state !== 4'b0101) begin
          n_fail++;
          $display("FAIL multi_wait edge+%0d got pe=%b ne=%b st=%b exp pe=0000 ne=0000 st=0101",
                   i, key_pressed_posedge, key_released_negedge, key_state);
        end
      end else begin
        n_tests++;
        if (key_pressed_posedge !== 4'b0010 || key_released_negedge !== 4'b0001 ||
            key_state !== 4'b0110 || key_any !== 1'b1) begin
          n_fail++;
          $display("FAIL multi_edge got pe=%b ne=%b st=%b any=%b exp pe=0010 ne=0001 st=0110 any=1",
                   key_pressed_posedge, key_released_negedge, key_state, key_any);
        end
      end
    end
    tick();
    n_tests++;
    if (key_pressed_posedge !== 4'b0000 || key_released_negedge !== 4'b0000) begin
      n_fail++;
      $display("FAIL multi_pulse_width got pe=%b ne=%b exp 0000 0000",
               key_pressed_posedge, key_released_negedge);
    end
    $display("[TB] test_multi_key done");
  endtask

  task automatic test_reset_mid();
    logic exp;
    apply_reset();
    key_pressed[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (key_pressed_posedge[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_press got pe=%b exp 1", key_pressed_posedge[0]);
    end
    for (int i = 0; i < 24; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({key_state, key_pressed_posedge, key_released_negedge, key_repeat, key_any} !== 17'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got st=%b pe=%b ne=%b rp=%b any=%b exp all 0",
               key_state, key_pressed_posedge, key_released_negedge, key_repeat, key_any);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i == 5);
      n_tests++;
      if (key_pressed_posedge[0] !== exp || key_state[0] !== exp) begin
        n_fail++;
        $display("FAIL rstmid_repress edge+%0d got pe=%b st=%b exp %b", i,
                 key_pressed_posedge[0], key_state[0], exp);
      end
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp = REP_EN && (k == 20);
      n_tests++;
      if (key_repeat[0] !== exp) begin
        n_fail++;
        $display("FAIL rstmid_repeat press+%0d got rp=%b exp %b", k, key_repeat[0], exp);
      end
    end
    key_pressed = 4'h0;
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    key_pressed = 4'h0;
    tick();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_auto_repeat();
    test_multi_key();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_key_event_gen.md
Name: keyboard_key_event_gen

Overview:
Parametrised per-key event generator for the keyboard path. Successor to the fixed 4-bit rising-edge detector. Takes N raw key-level signals from the keyboard decoder and outputs the following to the game-control FSMs:
- debounced key state
- one-cycle press and release pulses
- optional typematic auto-repeat pulses

One clock domain. Sits between the keyboard decoder and the game logic.

Parameters:
N_KEYS, 4, number of independent key channels (>=1)
DEBOUNCE_CYCLES, 16, consecutive differing samples required before the debounced state flips (>=1)
REPEAT_DELAY, 50_000_000, cycles from press pulse to first repeat pulse (>=1; used only with auto-repeat)
REPEAT_PERIOD, 10_000_000, cycles between later repeat pulses (>=1; used only with auto-repeat)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
key_pressed  input  N_KEYS  raw key levels from the decoder, 1 = held; may bounce
key_state  output  N_KEYS  debounced key level
key_pressed_posedge  output  N_KEYS  one-cycle pulse on debounced 0->1
key_released_negedge  output  N_KEYS  one-cycle pulse on debounced 1->0
key_repeat  output  N_KEYS  one-cycle typematic pulse while the key is held
key_any  output  1  OR of key_state

Behaviour:
- Reset (rst=1 sampled at posedge):
  - All internal registers clear to 0: sync, key_state, counters, repeat FSM.
  - All outputs are 0 in the cycle after the reset edge.
  - rst has priority over every other event.
  - A key held through reset produces a normal posedge pulse once debounced after reset is released.
- Channels are fully independent; there is no cross-channel priority.
- Input stage: key_pressed is registered once into key_sync (1 cycle).
- Debounce, per key, counter width $clog2(DEBOUNCE_CYCLES+1):
  - key_sync == key_state: counter <= 0.
  - key_sync != key_state and counter < DEBOUNCE_CYCLES-1: counter increments.
  - key_sync != key_state and counter == DEBOUNCE_CYCLES-1: key_state <= key_sync and counter <= 0.
  - A single agreeing sample restarts the count (glitch rejection).
- Latency: a clean raw edge produces the key_state change and its edge pulse exactly DEBOUNCE_CYCLES+1 posedges after the raw change.
- Edge pulses:
  - Registered, asserted in the same cycle key_state changes, high for exactly 1 cycle.
  - posedge and negedge are never both high on one key.
- Auto-repeat FSM, per key: states IDLE, DELAY, REPEAT; counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - IDLE -> DELAY on the debounced rise; counter cleared in the same cycle as key_pressed_posedge.
  - DELAY: counter counts. When counter == REPEAT_DELAY-1: pulse key_repeat, counter <= 0, go to REPEAT.
  - REPEAT: when counter == REPEAT_PERIOD-1: pulse key_repeat, counter <= 0.
  - Any state -> IDLE on the debounced fall. The counter clears and no repeat pulse is issued in the release cycle, even if the count would have expired then.
  - Result: first repeat at REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - key_repeat is never high in the same cycle as key_pressed_posedge.
- key_any is registered from the next-state key_state, so it changes in the same cycle as key_state.
- Wrap-around: counters never exceed their terminal value and never wrap.

Optional Feature:
Macro KEY_EVENT_AUTO_REPEAT_EN.
- Defined: the repeat FSM and counters above are built for each key.
- Undefined: no repeat logic is synthesised; key_repeat is tied to 0; REPEAT_DELAY and REPEAT_PERIOD are ignored. All other behaviour is unchanged.

Test Plan:
Bench settings: N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Clean press: key_pressed[0] 0->1 at edge t and held -> key_state[0] and key_pressed_posedge[0] rise at edge t+5; pulse width 1; key_any=1 from t+5.
- Bounce: key_pressed[1] toggles 1,0,1,0 on successive cycles, then stays 1 -> no pulse during the toggling; exactly one posedge pulse 5 edges after the final stable 1.
- Release: key 2 held, then released at edge r -> key_released_negedge[2] is a 1-cycle pulse at r+5; key_state[2]=0; no key_repeat after r+5.
- Auto-repeat (macro defined): key 3 held for 60 cycles after its press pulse at edge p -> key_repeat[3] pulses at p+20, p+28, p+36, p+44, p+52; release stops pulses. Macro undefined: key_repeat stays 0.
- Multi-key and simultaneous edges: key 0 released and key 1 pressed on the same raw cycle -> negedge[0] and posedge[1] pulse in the same cycle; the other channels are unaffected.
- Reset mid-operation: rst=1 for 1 cycle while key 0 is held and in the REPEAT state -> all outputs 0 the next cycle; key 0 still raw-high -> new posedge pulse 5 edges after rst deasserts; repeat timing restarts from 20.
